// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared scan states, digit entry layout and hex-to-segment decode
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DWELL = 2'd3
  } scan_state_e;

  localparam int ENT_W      = 6;
  localparam int ENT_BLANK  = 5;
  localparam int ENT_DP     = 4;
  localparam int ENT_HEX_HI = 3;

  localparam logic [ENT_W-1:0] ENT_RESET = 6'b100000;

  // Segment patterns g..a, digit 0 in the low seven bits up to F at the top.
  localparam logic [16*7-1:0] HEX_SEG_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] decode_entry(input logic [ENT_W-1:0] entry);
    logic [7:0] seg;
    seg = {entry[ENT_DP], HEX_SEG_TBL[entry[ENT_HEX_HI:0]*7 +: 7]};
    if (entry[ENT_BLANK]) begin
      seg = 8'h00;
    end
    return seg;
  endfunction

endpackage

// File: rtl/pwm_dimmer.sv
// rtl/pwm_dimmer.sv - dwell timer split into sixteen slices, blanks slices above the brightness level
module pwm_dimmer #(
  parameter int DWELL_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] brightness,
  output logic       last,
  output logic       dim_blank
);

  localparam int SUB_CYCLES = DWELL_CYCLES / 16;
  localparam int SUB_W      = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

  // Slice index is kept as its own counter so no divider is needed.
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       slice_q, slice_d;
  logic             sub_wrap;

  always_comb begin
    sub_wrap = (sub_q == SUB_W'(SUB_CYCLES - 1));
    sub_d    = sub_q;
    slice_d  = slice_q;
    if (!run) begin
      sub_d   = '0;
      slice_d = '0;
    end else if (sub_wrap) begin
      sub_d   = '0;
      slice_d = slice_q + 4'd1;
    end else begin
      sub_d = sub_q + SUB_W'(1);
    end
  end

  assign last      = run && sub_wrap && (slice_q == 4'hF);
  assign dim_blank = (slice_q > brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      slice_q <= '0;
    end else begin
      sub_q   <= sub_d;
      slice_q <= slice_d;
    end
  end

endmodule

// File: rtl/digit_scan_controller.sv
// rtl/digit_scan_controller.sv - multiplexed seven-segment scanner: digit store, load handshake, dwell
module digit_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 16384,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic [3:0] brightness,
  input  logic       shift_done,
  output logic       shift_req,
  output logic [7:0] anodes,
  output logic [7:0] segments,
  output logic       blank,
  output logic [2:0] digit_idx,
  output logic       timeout_err
);

  localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);

  scan_state_e       state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ENT_W-1:0]  store_q [NUM_DIGITS];
  logic [ENT_W-1:0]  store_d [NUM_DIGITS];
  logic              shift_req_q, shift_req_d;
  logic [7:0]        anodes_q, anodes_d;
  logic [7:0]        segments_q, segments_d;
  logic [2:0]        digit_idx_q, digit_idx_d;
  logic              timeout_err_q, timeout_err_d;
  logic              dwell_last;
  logic              dim_blank;

  pwm_dimmer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dimmer (
    .clk       (sysclk),
    .rst_n     (reset_n),
    .run       (state_q == DWELL),
    .brightness(brightness),
    .last      (dwell_last),
    .dim_blank (dim_blank)
  );

  always_comb begin
    store_d = store_q;
    if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      store_d[wr_addr] = wr_data;
    end
  end

  // Display outputs are registered on the LOAD cycle, so they appear together with shift_req.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wait_cnt_d    = wait_cnt_q;
    shift_req_d   = 1'b0;
    anodes_d      = anodes_q;
    segments_d    = segments_q;
    digit_idx_d   = digit_idx_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        anodes_d    = 8'h01 << idx_q;
        segments_d  = decode_entry(store_q[idx_q]);
        digit_idx_d = idx_q;
        shift_req_d = 1'b1;
        wait_cnt_d  = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (shift_done) begin
          state_d = DWELL;
        end else if (wait_cnt_q == WAIT_W'(DONE_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = DWELL;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      DWELL: begin
        if (dwell_last) begin
          idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
          if (enable) begin
            state_d = LOAD;
          end else begin
            state_d  = IDLE;
            anodes_d = 8'h00;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      shift_req_q   <= 1'b0;
      anodes_q      <= '0;
      segments_q    <= '0;
      digit_idx_q   <= '0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        store_q[i] <= ENT_RESET;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_cnt_q    <= wait_cnt_d;
      shift_req_q   <= shift_req_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
      digit_idx_q   <= digit_idx_d;
      timeout_err_q <= timeout_err_d;
      store_q       <= store_d;
    end
  end

  assign shift_req   = shift_req_q;
  assign anodes      = anodes_q;
  assign segments    = segments_q;
  assign digit_idx   = digit_idx_q;
  assign timeout_err = timeout_err_q;
  assign blank       = (state_q != DWELL) || dim_blank;

endmodule

// File: tb/tb_digit_scan_controller.sv
// tb/tb_digit_scan_controller.sv - self-checking bench for digit_scan_controller
module tb_digit_scan_controller;

  localparam int N     = 8;
  localparam int D     = 64;
  localparam int TO    = 64;
  localparam int BOUND = D + TO + 20;

  logic       sysclk;
  logic       reset_n;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic [3:0] brightness;
  logic       shift_done;
  logic       shift_req;
  logic [7:0] anodes;
  logic [7:0] segments;
  logic       blank;
  logic [2:0] digit_idx;
  logic       timeout_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [5:0] mdl [N];
  logic [6:0] hex_tbl [16];
  int         exp_idx;
  bit         exp_terr;

  digit_scan_controller #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(D),
    .DONE_TIMEOUT(TO)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .brightness (brightness),
    .shift_done (shift_done),
    .shift_req  (shift_req),
    .anodes     (anodes),
    .segments   (segments),
    .blank      (blank),
    .digit_idx  (digit_idx),
    .timeout_err(timeout_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [5:0] e);
    if (e[5]) return 8'h00;
    return {e[4], hex_tbl[e[3:0]]};
  endfunction

  task automatic start_scan();
    enable = 1'b1;
    step();
    chk("req_early", shift_req, 0);
    step();
    chk("req_latency", shift_req, 1);
  endtask

  // Entered at the cycle where shift_req is seen; returns at the next request (or in IDLE if drop).
  task automatic scan_one(input int lat, input int bright, input bit do_wr,
                          input logic [2:0] waddr, input logic [5:0] wdata,
                          input bit spur, input bit drop);
    int   cyc;
    int   lit;
    int   t_rise;
    bit   got;
    bit   unstable;
    logic [7:0] an0;
    logic [7:0] sg0;
    brightness = bright[3:0];
    chk("digit_idx", digit_idx, exp_idx);
    chk("anodes", anodes, 8'h01 << exp_idx);
    chk("segments", segments, exp_seg(mdl[exp_idx]));
    an0        = anodes;
    sg0        = segments;
    wr_addr    = waddr;
    wr_data    = wdata;
    shift_done = (lat == 0);
    cyc = 0; lit = 0; t_rise = -1; got = 0; unstable = 0;
    while (cyc < BOUND) begin
      step();
      cyc++;
      wr_en      = do_wr && (lat >= 0) && (cyc == lat + 5);
      shift_done = (cyc == lat) || (spur && lat >= 0 && cyc == lat + 10);
      if (drop && cyc == lat + 20) enable = 1'b0;
      if (timeout_err === 1'b1 && t_rise < 0) t_rise = cyc;
      if (shift_req === 1'b1) begin
        got = 1;
        break;
      end
      if (drop && cyc == lat + D + 1) break;
      if (blank === 1'b0) lit++;
      if (anodes !== an0 || segments !== sg0) unstable = 1;
    end
    shift_done = 1'b0;
    wr_en      = 1'b0;
    chk("lit_cycles", lit, (bright + 1) * (D / 16));
    chk("display_stable", unstable, 0);
    if (drop) begin
      chk("drop_no_req", got, 0);
      chk("drop_anodes", anodes, 0);
      chk("drop_blank", blank, 1);
    end else begin
      chk("req_seen", got, 1);
      chk("req_period", cyc, (lat < 0) ? (TO + D + 1) : (lat + D + 2));
    end
    if (lat < 0) begin
      chk("timeout_onset", t_rise, TO);
      exp_terr = 1'b1;
    end
    chk("timeout_err", timeout_err, exp_terr);
    if (do_wr && lat >= 0) mdl[waddr] = wdata;
    exp_idx = (exp_idx + 1) % N;
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset_n = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    brightness = 4'hF; shift_done = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_anodes", anodes, 0);
    chk("rst_segments", segments, 0);
    chk("rst_req", shift_req, 0);
    chk("rst_blank", blank, 1);
    chk("rst_idx", digit_idx, 0);
    chk("rst_terr", timeout_err, 0);
    for (int i = 0; i < N; i++) mdl[i] = 6'b100000;
    exp_idx = 0; exp_terr = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("idle_no_req", shift_req, 0);
    chk("idle_blank", blank, 1);

    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 6'(i + 1);
      step();
      mdl[i] = 6'(i + 1);
    end
    wr_en = 1'b0;

    start_scan();
    repeat (N + 1) scan_one(3, 15, 0, 3'd0, 6'd0, 0, 0);
    repeat (3) scan_one(3, 3, 0, 3'd0, 6'd0, 0, 0);

    while (exp_idx != 2) scan_one(3, 15, 0, 3'd0, 6'd0, 0, 0);
    scan_one(3, 3, 1, 3'd2, 6'b010000, 0, 0);
    repeat (N - 1) scan_one(3, 15, 0, 3'd0, 6'd0, 0, 0);
    scan_one(3, 15, 1, 3'd2, {1'b1, 5'($urandom)}, 0, 0);
    repeat (N - 1) scan_one(3, 15, 0, 3'd0, 6'd0, 0, 0);

    repeat (12) scan_one($urandom_range(0, 6), $urandom_range(0, 15), bit'($urandom_range(0, 1)),
                         3'($urandom), 6'($urandom), bit'($urandom_range(0, 1)), 0);

    while (exp_idx != 4) scan_one($urandom_range(0, 6), 15, 0, 3'd0, 6'd0, 1, 0);
    scan_one(3, 7, 0, 3'd0, 6'd0, 0, 1);
    step(); step();
    chk("idle_hold_req", shift_req, 0);
    chk("idle_hold_anodes", anodes, 0);
    start_scan();
    scan_one(2, 15, 0, 3'd0, 6'd0, 0, 0);

    scan_one(-1, 15, 0, 3'd0, 6'd0, 0, 0);
    repeat (3) scan_one($urandom_range(0, 6), $urandom_range(0, 15), 0, 3'd0, 6'd0, 0, 0);

    step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_anodes", anodes, 0);
    chk("arst_segments", segments, 0);
    chk("arst_req", shift_req, 0);
    chk("arst_blank", blank, 1);
    chk("arst_idx", digit_idx, 0);
    chk("arst_terr", timeout_err, 0);
    for (int i = 0; i < N; i++) mdl[i] = 6'b100000;
    exp_idx = 0; exp_terr = 1'b0;
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    start_scan();
    repeat (N) scan_one($urandom_range(0, 6), $urandom_range(0, 15), 0, 3'd0, 6'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/digit_scan_controller.md
Name: digit_scan_controller

Overview:
- Time-multiplexed scan sequencer for the 8-digit seven-segment display.
- Holds one character per digit and steps through the digits in turn.
- For each digit it decodes the segment pattern and requests a serial load from the downstream shifter over a req/done handshake.
- It then holds the digit for a dwell period, with PWM blanking for brightness. Sits between the register/CPU side and the shift-register serializer.

Parameters:
- NUM_DIGITS, 8, digits scanned, 2..8; idx wraps at NUM_DIGITS-1.
- DWELL_CYCLES, 16384, sysclk cycles each digit is held; multiple of 16, >=16.
- DONE_TIMEOUT, 64, max cycles in WAIT before a forced advance.

Ports:
- sysclk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enabled.
- wr_en  in  1  write strobe into digit store.
- wr_addr  in  3  digit index for the write.
- wr_data  in  6  [5] blank digit, [4] decimal point, [3:0] hex value.
- brightness  in  4  on-time in sixteenths minus one; 15 = always on.
- shift_done  in  1  serializer finished latching, 1-cycle pulse.
- shift_req  out  1  1-cycle pulse, start serial load.
- anodes  out  8  one-hot digit select, active high.
- segments  out  8  [6:0] = g..a, [7] = dp, active high.
- blank  out  1  display blank, 1 = dark.
- digit_idx  out  3  digit currently scanned.
- timeout_err  out  1  sticky: a WAIT timed out.

Behaviour:
- Reset (async, any state): state=IDLE; idx=0; all counters 0; anodes=0; segments=0; shift_req=0; blank=1; digit_idx=0; timeout_err=0. Every digit store entry = 6'b100000 (blanked).
- Writes:
  - wr_en with wr_addr<NUM_DIGITS updates the entry on the next edge; wr_addr>=NUM_DIGITS is ignored.
  - Writes are legal in any state. A digit's entry is snapshotted only in LOAD, so a write to the digit being displayed appears on that digit's next visit.
- IDLE: blank=1, anodes=0. When enable=1, go to LOAD next cycle.
- LOAD (1 cycle):
  - anodes <= 1<<idx.
  - segments <= decode(entry[idx]), or 0 if its blank bit is set.
  - digit_idx <= idx; shift_req=1 for this cycle only; blank=1; go to WAIT.
- WAIT:
  - blank=1; wait counter increments.
  - shift_done=1: go to DWELL, dwell counter cleared.
  - Counter reaches DONE_TIMEOUT-1 without shift_done: set timeout_err, go to DWELL anyway.
  - shift_done arriving in any other state is ignored.
- DWELL:
  - Dwell counter runs 0..DWELL_CYCLES-1; slice = counter / (DWELL_CYCLES/16).
  - blank = (slice > brightness); brightness=15 means blank never asserts in DWELL.
  - Last cycle: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. Go to LOAD if enable=1, else IDLE.
- enable is sampled only in IDLE and at the end of DWELL; deassertion mid-LOAD/WAIT/DWELL completes the current digit.
- Latency: enable rise to shift_req = 2 cycles (IDLE->LOAD, pulse during LOAD).
- anodes/segments stay stable from LOAD until the next LOAD; blank covers the shift window.
- Hex decode: full 0-F table (A,b,C,d,E,F).

Decomposition:
- Package seg7_pkg holds:
  - 16-entry hex-to-segment constant table and decode function.
  - Scan state enum (IDLE, LOAD, WAIT, DWELL).
  - 6-bit digit entry field positions.
- One natural sub-module, pwm_dimmer: dwell counter plus slice compare producing blank. The digit store and FSM stay in the top.

Test Plan:
- Reset, then write 1,2,3,4,5,6,7,8 to addr 0..7, enable=1, shift_done 3 cycles after each req: anodes cycles 01,02,..,80,01 and segments show 0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F. shift_req period = DWELL_CYCLES+5 cycles.
- brightness=3, DWELL_CYCLES=64: within each dwell, blank=0 for exactly 16 cycles, then 1 for 48. brightness=15 gives blank=0 for all 64.
- Never assert shift_done, DONE_TIMEOUT=64: timeout_err rises 64 cycles after the first shift_req, scan still advances, and timeout_err stays 1.
- wr_data=6'b010000 to addr 2 while digit 2 is in DWELL: segments unchanged until the next visit to digit 2, then 0xBF. Write 6'b1xxxxx: segments=0.
- Drop enable mid-DWELL of digit 4: finishes the dwell, goes to IDLE with blank=1 and anodes=0. Re-enable: the next LOAD shows digit 5.
- Assert reset_n=0 mid-WAIT, asynchronously: outputs go to reset values with no clock edge; store is blanked; timeout_err=0.
